mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
Multicycle control sequencer for the 32-bit MIPS-subset datapath. It steps each instruction through fetch, decode, execute, memory and writeback states. In every state it drives the select lines of the datapath muxes (2:1 and 3:1) and the register, PC and memory enables. Instruction and data memory accesses use a req/rdy handshake, so memory wait states stall the sequencer.

Parameters:
PC_INC, 1, when 1 FETCH selects constant 4 on ALU B; when 0 the PC increment is performed externally and alu_src_b is 00 in FETCH.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  6  IR[31:26], valid from DECODE onward
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag, same cycle
mem_rdy  in  1  memory completes current access this cycle
mem_req  out  1  memory access request
mem_write  out  1  access is a write (qualifies mem_req)
iord  out  1  mux2 select: 0 = PC address, 1 = ALUOut address
ir_write  out  1  latch instruction register
pc_en  out  1  PC load enable
pc_src  out  2  mux3_32 select: 00 ALU result, 01 ALUOut, 10 jump target
alu_src_a  out  1  0 = PC, 1 = reg A
alu_src_b  out  2  00 reg B, 01 const 4, 10 sext imm, 11 sext imm<<2
alu_ctrl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
reg_dst  out  1  0 = rt, 1 = rd
mem_to_reg  out  1  0 = ALUOut, 1 = MDR
reg_write  out  1  register file write enable
illegal  out  1  one-cycle pulse on an unsupported op/funct
state  out  4  current state, for debug

Behaviour:
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12-15 return to FETCH on the next edge with all outputs inactive.
- Reset: while rst_n=0, state=FETCH and illegal=0. All enables are forced 0 combinationally: mem_req, mem_write, ir_write, pc_en, reg_write. After release, FETCH begins on the first edge. Reset mid-instruction abandons it; no partial writeback occurs.
- Outputs are Moore-decoded from state, except pc_en and ir_write, which are also qualified by mem_rdy/zero as listed. Any select not listed for a state is 0 (alu_ctrl 010).
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl=add, pc_src=00. ir_write=pc_en=mem_rdy. The FSM holds in FETCH until mem_rdy=1, then goes to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, add (branch target into ALUOut). Next state by op:
  - 100011 (lw) / 101011 (sw) -> MEMADR
  - 000000 -> EXEC
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JUMP
  - any other op -> FETCH, with illegal=1 for one cycle, registered (asserted in the first FETCH cycle).
- MEMADR: alu_src_a=1, alu_src_b=10, add. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, iord=1. Holds until mem_rdy, then goes to MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Goes to FETCH.
- MEMWR: mem_req=1, mem_write=1, iord=1. Holds until mem_rdy, then goes to FETCH.
- EXEC: alu_src_a=1, alu_src_b=00. alu_ctrl from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Unknown funct: goes to FETCH with illegal pulse; no writeback.
  - Otherwise goes to ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1. alu_ctrl holds the EXEC value. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01, pc_en=zero. Goes to FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, add. Goes to ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1. Goes to FETCH.
- JUMP: pc_src=10, pc_en=1. Goes to FETCH.
- Latency with mem_rdy tied 1: lw 5 cycles; sw, R-type and addi 4; beq and j 3. Each mem_rdy=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- mem_rdy is ignored in states with mem_req=0.

Test Plan:
- Reset: hold rst_n=0 with mem_rdy=1 -> all enables 0, state=0. Release -> FETCH asserts ir_write=pc_en=1 on the first cycle.
- lw (op=100011), mem_rdy low for 2 cycles in MEMRD -> state sequence 0,1,2,3,3,3,4,0; reg_write=1 with mem_to_reg=1 only in state 4; 7 cycles total.
- R-type sub (funct=100010), mem_rdy=1 -> states 0,1,6,7,0; alu_ctrl=110 in states 6 and 7; reg_dst=1 and reg_write=1 in state 7.
- beq taken vs not taken: zero=1 in BRANCH -> pc_en=1, pc_src=01; zero=0 -> pc_en=0. Both cases return to FETCH after 3 cycles.
- Illegal op=111111 -> DECODE goes to FETCH; illegal=1 for exactly 1 cycle; no reg_write or mem_write at any point.
- sw with rst_n pulsed low during MEMWR -> mem_write drops immediately (asynchronous); state=0 after release; no reg_write.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle MIPS-subset control sequencer driving datapath selects/enables.
// Outputs decode from the registered state; memory waits stall via mem_rdy.
module mc_ctrl_fsm #(
  parameter bit PC_INC = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_rdy,
  output logic       mem_req,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;
  state_t     state_q;
  logic       illegal_q;
  logic [2:0] alu_q;
  logic [2:0] funct_ctrl;
  logic       funct_ok;
  always_comb begin
    funct_ok   = 1'b1;
    funct_ctrl = 3'b010;
    case (funct)
      6'b100000: funct_ctrl = 3'b010;
      6'b100010: funct_ctrl = 3'b110;
      6'b100100: funct_ctrl = 3'b000;
      6'b100101: funct_ctrl = 3'b001;
      6'b101010: funct_ctrl = 3'b111;
      default:   funct_ok   = 1'b0;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
      alu_q     <= 3'b010;
    end else begin
      illegal_q <= 1'b0;
      case (state_q)
        FETCH:  if (mem_rdy) state_q <= DECODE;
        DECODE: begin
          case (op)
            6'b100011, 6'b101011: state_q <= MEMADR;
            6'b000000:            state_q <= EXEC;
            6'b000100:            state_q <= BRANCH;
            6'b001000:            state_q <= ADDIEX;
            6'b000010:            state_q <= JUMP;
            default: begin
              state_q   <= FETCH;
              illegal_q <= 1'b1;
            end
          endcase
        end
        MEMADR: state_q <= (op == 6'b101011) ? MEMWR : MEMRD;
        MEMRD:  if (mem_rdy) state_q <= MEMWB;
        MEMWR:  if (mem_rdy) state_q <= FETCH;
        EXEC: begin
          alu_q     <= funct_ctrl;
          state_q   <= funct_ok ? ALUWB : FETCH;
          illegal_q <= ~funct_ok;
        end
        ADDIEX: state_q <= ADDIWB;
        default: state_q <= FETCH;
      endcase
    end
  end
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_ctrl   = 3'b010;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = PC_INC ? 2'b01 : 2'b00;
        ir_write  = mem_rdy;
        pc_en     = mem_rdy;
      end
      DECODE: alu_src_b = 2'b11;
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_ctrl  = funct_ctrl;
      end
      ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        alu_ctrl  = alu_q;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctrl  = 3'b110;
        pc_src    = 2'b01;
        pc_en     = zero;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ADDIWB: reg_write = 1'b1;
      JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
      default: ;
    endcase
    // enables are cut immediately by reset so an abandoned instruction writes nothing
    if (!rst_n) begin
      mem_req   = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_en     = 1'b0;
      reg_write = 1'b0;
    end
  end
  assign state   = state_q;
  assign illegal = illegal_q;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: random instruction stream checked every cycle against a per-instruction step-list model,
// plus directed sequences with literal expectations.
module tb_mc_ctrl_fsm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] op = '0, funct = '0;
  logic zero = 1'b0, mem_rdy = 1'b1;
  logic mem_req, mem_write, iord, ir_write, pc_en, alu_src_a, reg_dst, mem_to_reg, reg_write, illegal;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_ctrl;
  logic [3:0] state;
  logic [16:0] act;
  mc_ctrl_fsm #(.PC_INC(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_rdy(mem_rdy),
    .mem_req(mem_req), .mem_write(mem_write), .iord(iord), .ir_write(ir_write), .pc_en(pc_en),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .illegal(illegal), .state(state)
  );
  always #5 clk = ~clk;
  assign act = {mem_req, mem_write, iord, ir_write, pc_en, pc_src, alu_src_a, alu_src_b, alu_ctrl,
                reg_dst, mem_to_reg, reg_write};
  int n_pass = 0, n_chk = 0;
  int seq[$];
  int idx = 0;
  bit need_new = 1'b1, ill_end = 1'b0, ill_pending = 1'b0;
  bit f_valid = 1'b0;
  logic [5:0] f_op, f_funct;
  logic [2:0] ac_m = 3'b010;
  logic [5:0] ops[10] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010,
                          6'b111111, 6'b000001, 6'b001101, 6'b100000};
  logic [5:0] fl[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, a, e, $time);
  endtask
  function automatic logic [16:0] exp_out(input int st, input logic rdy, input logic z, input logic [2:0] ac);
    logic mreq = 0, mwr = 0, io = 0, irw = 0, pce = 0, asa = 0, rd = 0, m2r = 0, rw = 0;
    logic [1:0] ps = 0, asb = 0;
    logic [2:0] ctl = 3'b010;
    case (st)
      0: begin mreq = 1; asb = 2'b01; irw = rdy; pce = rdy; end
      1: asb = 2'b11;
      2: begin asa = 1; asb = 2'b10; end
      3: begin mreq = 1; io = 1; end
      4: begin m2r = 1; rw = 1; end
      5: begin mreq = 1; mwr = 1; io = 1; end
      6: begin asa = 1; ctl = ac; end
      7: begin rd = 1; rw = 1; ctl = ac; end
      8: begin asa = 1; ctl = 3'b110; ps = 2'b01; pce = z; end
      9: begin asa = 1; asb = 2'b10; end
      10: rw = 1;
      11: begin ps = 2'b10; pce = 1; end
      default: ;
    endcase
    return {mreq, mwr, io, irw, pce, ps, asa, asb, ctl, rd, m2r, rw};
  endfunction
  task automatic force_ins(input logic [5:0] o, input logic [5:0] f);
    f_valid = 1'b1; f_op = o; f_funct = f;
  endtask
  // an instruction is the ordered list of steps it visits; memory steps repeat while mem_rdy is low
  task automatic new_ins();
    logic [5:0] o, f;
    bit fok;
    if (f_valid) begin
      o = f_op; f = f_funct; f_valid = 1'b0;
    end else begin
      o = ops[$urandom_range(0, 9)];
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fl[$urandom_range(0, 4)];
    end
    op = o; funct = f;
    fok = 1'b1;
    case (f)
      6'b100000: ac_m = 3'b010;
      6'b100010: ac_m = 3'b110;
      6'b100100: ac_m = 3'b000;
      6'b100101: ac_m = 3'b001;
      6'b101010: ac_m = 3'b111;
      default: begin ac_m = 3'b010; fok = 1'b0; end
    endcase
    ill_end = 1'b0;
    case (o)
      6'b100011: seq = '{0, 1, 2, 3, 4};
      6'b101011: seq = '{0, 1, 2, 5};
      6'b000000: if (fok) seq = '{0, 1, 6, 7}; else begin seq = '{0, 1, 6}; ill_end = 1'b1; end
      6'b000100: seq = '{0, 1, 8};
      6'b001000: seq = '{0, 1, 9, 10};
      6'b000010: seq = '{0, 1, 11};
      default: begin seq = '{0, 1}; ill_end = 1'b1; end
    endcase
    idx = 0; need_new = 1'b0;
  endtask
  task automatic cyc(input logic rdy, input logic z);
    int st;
    @(negedge clk);
    if (need_new) new_ins();
    mem_rdy = rdy; zero = z;
    #1;
    st = seq[idx];
    chk("state", 32'(state), st);
    chk("outputs", 32'(act), 32'(exp_out(st, rdy, z, ac_m)));
    chk("illegal", 32'(illegal), 32'(ill_pending));
    ill_pending = 1'b0;
    if (!((st == 0 || st == 3 || st == 5) && !rdy)) begin
      idx++;
      if (idx == seq.size()) begin
        need_new = 1'b1;
        ill_pending = ill_end;
      end
    end
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int lw_st[7] = '{0, 1, 2, 3, 3, 3, 4};
    logic lw_rdy[7] = '{1, 1, 1, 0, 0, 1, 1};
    int guard;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_enables", 32'({mem_req, mem_write, ir_write, pc_en, reg_write}), 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_illegal", 32'(illegal), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    force_ins(6'b100011, 6'b000000);
    for (int i = 0; i < 7; i++) begin
      cyc(lw_rdy[i], 1'b0);
      chk("lw_state", 32'(state), lw_st[i]);
      if (i == 0) chk("rel_irw_pcen", 32'({ir_write, pc_en}), 32'h3);
      if (i == 6) chk("lw_wb", 32'({reg_write, mem_to_reg}), 32'h3);
    end
    force_ins(6'b000000, 6'b100010);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0);
      if (i == 0) chk("lw_end_state", 32'(state), 0);
      if (i >= 2) chk("sub_alu", 32'(alu_ctrl), 32'h6);
      if (i == 3) chk("sub_wb", 32'({state, reg_dst, reg_write}), 32'h1f);
    end
    for (int t = 0; t < 2; t++) begin
      force_ins(6'b000100, 6'b000000);
      for (int i = 0; i < 3; i++) cyc(1'b1, t == 0);
      chk("beq_state", 32'(state), 8);
      chk("beq_pcen", 32'({pc_en, pc_src}), (t == 0) ? 32'h5 : 32'h1);
    end
    force_ins(6'b111111, 6'b000000);
    cyc(1'b1, 1'b0);
    chk("ill_first", 32'(state), 0);
    cyc(1'b1, 1'b0);
    chk("ill_decode", 32'(state), 1);
    force_ins(6'b000010, 6'b000000);
    cyc(1'b1, 1'b0);
    chk("ill_pulse", 32'({state, illegal}), 32'h1);
    cyc(1'b1, 1'b0);
    chk("ill_clear", 32'({state, illegal}), 32'h2);
    cyc(1'b1, 1'b0);
    chk("jump", 32'({state, pc_en, pc_src}), 32'h5e);
    for (int i = 0; i < 400; i++) cyc($urandom_range(0, 3) != 0, 1'($urandom));
    guard = 0;
    while (!need_new && guard < 20) begin
      cyc($urandom_range(0, 3) != 0, 1'($urandom));
      guard++;
    end
    chk("boundary_reached", 32'(need_new), 1);
    force_ins(6'b101011, 6'b000000);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk("sw_memwr", 32'({state, mem_write}), 32'hb);
    rst_n = 1'b0;
    #1;
    chk("async_rst_enables", 32'({mem_req, mem_write, reg_write}), 0);
    chk("async_rst_state", 32'(state), 0);
    mem_rdy = 1'b1;
    @(posedge clk);
    #2;
    chk("rst_hold", 32'({state, ir_write, pc_en, illegal}), 0);
    rst_n = 1'b1;
    need_new = 1'b1; ill_pending = 1'b0;
    cyc(1'b1, 1'b0);
    chk("post_rst_fetch", 32'({state, ir_write}), 32'h1);
    for (int i = 0; i < 30; i++) cyc($urandom_range(0, 3) != 0, 1'($urandom));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
